// File: rtl/frv_wb_arb_pkg.sv
// Shared types and constants for the FazyRV dual-master Wishbone arbiter.
package frv_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [31:0] TOUT_DATA = 32'hDEAD_BEEF;
  localparam int          TOUT_W    = 16;

  // Counter value at which the watchdog fires for a given timeout length.
  function automatic logic [TOUT_W-1:0] tout_last(input int cycles);
    return TOUT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/frv_wb_arbiter_if.sv
// Classic Wishbone bus bundle (one master, one slave) used to wire the arbiter.
// Handshake: a request is live while cyc & stb; the slave answers with a single-cycle ack,
// read data is valid on dat_r only while ack is high; the master holds all fields until ack.
interface frv_wb_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  be;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, be, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, be, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/frv_wb_arb_wdog.sv
// Bus-timeout watchdog: counts grant cycles without ack and raises a sticky timeout flag.
module frv_wb_arb_wdog
  import frv_wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic active_i,
  input  logic ack_i,
  output logic fire_o,
  output logic tout_o
);

  logic [TOUT_W-1:0] cnt_q;
  logic              tout_q;

  // A real ack in the final cycle wins, so fire is masked by ack.
  assign fire_o = active_i & ~ack_i & (cnt_q == tout_last(TIMEOUT_CYCLES));
  assign tout_o = tout_q;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      if (!active_i || fire_o) begin
        cnt_q <= '0;
      end else if (!ack_i) begin
        cnt_q <= cnt_q + TOUT_W'(1);
      end
      if (fire_o) begin
        tout_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/frv_wb_arbiter.sv
// Round-robin arbiter merging FazyRV imem/dmem Wishbone masters onto one shared port.
// Optional bus-timeout watchdog enabled by defining FRV_WB_ARB_TIMEOUT_EN.
module frv_wb_arbiter
  import frv_wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter bit FIRST_PRIO_DMEM = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        wb_imem_stb_i,
  input  logic        wb_imem_cyc_i,
  input  logic [31:0] wb_imem_adr_i,
  output logic [31:0] wb_imem_dat_o,
  output logic        wb_imem_ack_o,
  input  logic        wb_dmem_cyc_i,
  input  logic        wb_dmem_stb_i,
  input  logic        wb_dmem_we_i,
  input  logic [3:0]  wb_dmem_be_i,
  input  logic [31:0] wb_dmem_adr_i,
  input  logic [31:0] wb_dmem_dat_i,
  output logic [31:0] wb_dmem_dat_o,
  output logic        wb_dmem_ack_o,
  output logic        wb_mem_cyc_o,
  output logic        wb_mem_stb_o,
  output logic        wb_mem_we_o,
  output logic [3:0]  wb_mem_be_o,
  output logic [31:0] wb_mem_adr_o,
  output logic [31:0] wb_mem_dat_o,
  input  logic [31:0] wb_mem_dat_i,
  input  logic        wb_mem_ack_i,
  output logic        tout_o,
  output state_t      dbg_state_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_tout_range
    $error("frv_wb_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t state_q;
  logic   lg_q;      // last grant from a contended arbitration: 1 = dmem, 0 = imem
  logic   req_i;
  logic   req_d;
  logic   fire;
  logic   tout;

  assign req_i       = wb_imem_cyc_i & wb_imem_stb_i;
  assign req_d       = wb_dmem_cyc_i & wb_dmem_stb_i;
  assign dbg_state_o = state_q;
  assign tout_o      = tout;

`ifdef FRV_WB_ARB_TIMEOUT_EN
  frv_wb_arb_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_in   (rst_in),
    .active_i (state_q != IDLE),
    .ack_i    (wb_mem_ack_i),
    .fire_o   (fire),
    .tout_o   (tout)
  );
`else
  assign fire = 1'b0;
  assign tout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      lg_q    <= ~FIRST_PRIO_DMEM;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i && req_d) begin
            if (lg_q) begin
              state_q <= GNT_I;
              lg_q    <= 1'b0;
            end else begin
              state_q <= GNT_D;
              lg_q    <= 1'b1;
            end
          end else if (req_i) begin
            state_q <= GNT_I;
          end else if (req_d) begin
            state_q <= GNT_D;
          end
        end
        // Completion, abort and timeout all return through IDLE for one bubble cycle.
        GNT_I: if (!wb_imem_cyc_i || wb_mem_ack_i || fire) state_q <= IDLE;
        GNT_D: if (!wb_dmem_cyc_i || wb_mem_ack_i || fire) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wb_mem_cyc_o  = 1'b0;
    wb_mem_stb_o  = 1'b0;
    wb_mem_we_o   = 1'b0;
    wb_mem_be_o   = 4'h0;
    wb_mem_adr_o  = 32'h0;
    wb_mem_dat_o  = 32'h0;
    wb_imem_ack_o = 1'b0;
    wb_imem_dat_o = 32'h0;
    wb_dmem_ack_o = 1'b0;
    wb_dmem_dat_o = 32'h0;
    case (state_q)
      GNT_I: begin
        wb_mem_cyc_o  = wb_imem_cyc_i & ~fire;
        wb_mem_stb_o  = wb_imem_stb_i & ~fire;
        wb_mem_be_o   = 4'hF;
        wb_mem_adr_o  = wb_imem_adr_i;
        wb_imem_ack_o = wb_imem_cyc_i & (wb_mem_ack_i | fire);
        wb_imem_dat_o = fire ? TOUT_DATA : wb_mem_dat_i;
      end
      GNT_D: begin
        wb_mem_cyc_o  = wb_dmem_cyc_i & ~fire;
        wb_mem_stb_o  = wb_dmem_stb_i & ~fire;
        wb_mem_we_o   = wb_dmem_we_i;
        wb_mem_be_o   = wb_dmem_be_i;
        wb_mem_adr_o  = wb_dmem_adr_i;
        wb_mem_dat_o  = wb_dmem_dat_i;
        wb_dmem_ack_o = wb_dmem_cyc_i & (wb_mem_ack_i | fire);
        wb_dmem_dat_o = fire ? TOUT_DATA : wb_mem_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/frv_wb_arbiter.md
Name: frv_wb_arbiter

Overview:
- Sits directly downstream of the FazyRV core wrapper.
- Merges the core's two Wishbone masters (imem, read-only; dmem, read/write) onto one shared Wishbone master port toward on-chip SRAM or the external memory controller.
- Round-robin arbitration with a registered grant, one request in flight at a time.
- Optional bus-timeout watchdog, so a hung slave cannot stall the core forever.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in a grant state without shared ack before the watchdog fires (watchdog build only). Legal range 1..65535.
- FIRST_PRIO_DMEM, 1: which master wins the first simultaneous request after reset. 1 = dmem, 0 = imem.

Ports:
- clk_i  in  1  clock.
- rst_in  in  1  asynchronous active-low reset.
- wb_imem_stb_i / wb_imem_cyc_i  in  1  imem master strobe / cycle.
- wb_imem_adr_i  in  32  imem address.
- wb_imem_dat_o  out  32  imem read data.
- wb_imem_ack_o  out  1  imem acknowledge.
- wb_dmem_cyc_i / wb_dmem_stb_i / wb_dmem_we_i  in  1  dmem control.
- wb_dmem_be_i  in  4  dmem byte enables.
- wb_dmem_adr_i / wb_dmem_dat_i  in  32  dmem address / write data.
- wb_dmem_dat_o  out  32  dmem read data.
- wb_dmem_ack_o  out  1  dmem acknowledge.
- wb_mem_cyc_o / wb_mem_stb_o / wb_mem_we_o  out  1  shared bus control.
- wb_mem_be_o  out  4  shared byte enables.
- wb_mem_adr_o / wb_mem_dat_o  out  32  shared address / write data.
- wb_mem_dat_i  in  32  shared read data.
- wb_mem_ack_i  in  1  shared acknowledge.
- tout_o  out  1  sticky timeout flag.

Behaviour:
- **States:** IDLE, GNT_I, GNT_D. The state register and last-grant bit (lg) are reset asynchronously to IDLE and lg = !FIRST_PRIO_DMEM.
- **Request:** a master requests when cyc & stb.
- **IDLE transitions:**
  - Only imem requests -> GNT_I.
  - Only dmem requests -> GNT_D.
  - Both request -> grant the master not in lg (round-robin), and update lg to the granted master.
  - Arbitration costs exactly 1 cycle. The shared bus is idle in the IDLE cycle.
- **Grant states:**
  - Shared cyc/stb/we/be/adr/dat are driven combinationally from the granted master's inputs, gated by state.
  - For imem, we = 0, be = 4'hF and dat_o = 0.
  - In IDLE, all shared outputs are 0.
- **Ack routing:** wb_mem_ack_i is routed combinationally to the granted master's ack only. wb_mem_dat_i is routed to the granted master's dat_o. The non-granted master's ack is always 0 and its dat_o is 0.
- **Completion:** on a shared ack in a grant state, the next state is IDLE. Back-to-back accesses therefore have one bubble cycle, which guarantees round-robin fairness.
- **Abort:** if the granted master drops cyc before ack, the shared cyc drops in the same cycle and the next state is IDLE. Any late ack from the slave is ignored.
- **Reset:**
  - Reset outputs: all acks, all shared control outputs and tout_o are 0. All data outputs are 0.
  - Reset mid-transaction returns to IDLE immediately. The slave sees cyc fall asynchronously.
- **Ack in IDLE:** a shared ack while in IDLE is ignored.
- **Protocol note:** slave ack is assumed single-cycle per request (classic Wishbone, no pipelining).

Optional Feature:
- Macro FRV_WB_ARB_TIMEOUT_EN.
- **Defined:**
  - A 16-bit counter clears on entry to a grant state and increments each grant-state cycle without wb_mem_ack_i.
  - When the counter equals TIMEOUT_CYCLES-1 and there is no ack:
    - the granted master receives ack = 1 with dat_o = 32'hDEAD_BEEF;
    - shared cyc/stb drop in that same cycle;
    - the next state is IDLE;
    - tout_o sets and stays set until reset.
  - A real ack in the same cycle takes precedence and is not a timeout.
- **Undefined:** no counter is built and tout_o is tied 0.

Decomposition:
- Package frv_wb_arb_pkg holds:
  - the state typedef enum logic [1:0] {IDLE, GNT_I, GNT_D};
  - the localparam TOUT_DATA = 32'hDEAD_BEEF;
  - the localparam TOUT_W = 16.
- Sub-module frv_wb_arb_wdog holds the timeout counter and sticky flag (inputs: active, ack; outputs: fire, tout). It is instantiated only under the macro.

Test Plan:
- **Single imem read:** imem requests adr 0x30; slave acks after 2 cycles with 0x00000013 -> shared cyc rises 1 cycle after request; imem ack with 0x00000013; dmem ack stays 0.
- **Simultaneous requests after reset (FIRST_PRIO_DMEM=1):** -> dmem is served first, then imem after one bubble. A second simultaneous pair -> imem first, because lg alternates.
- **dmem write:** adr 0x1000, be 4'b0011, dat 0xAABBCCDD -> shared we=1, be=4'b0011, dat 0xAABBCCDD; dmem ack on slave ack.
- **Abort:** imem drops cyc 1 cycle into the grant -> shared cyc low in the same cycle; state IDLE; a later slave ack produces no master ack.
- **Reset mid-grant:** rst_in low while in GNT_D -> all outputs 0 asynchronously; after release, a pending imem request is granted first (FIRST_PRIO_DMEM=1 case, only imem pending).
- **Timeout (macro defined, TIMEOUT_CYCLES=4):** slave never acks -> dmem ack with 0xDEADBEEF on the 4th grant cycle; tout_o = 1 and stays set; a subsequent normal access completes correctly.
